// File: rtl/cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cdb_arbiter                                                 |
// | Purpose  : Round-robin arbiter for the common data bus. Picks one      |
// |            functional unit with a ready result, grants it the bus,     |
// |            then broadcasts tag/value to the stations and writes the    |
// |            register file.                                              |
// | Ports    : Clock, Reset        - clock, synchronous active-high reset  |
// |            Done[N]             - per-source result-ready request       |
// |            Tag_in[3N]          - per-source station tag (0 = none)     |
// |            Value_in[WN]        - per-source result value               |
// |            R_target_in[3N]     - per-source destination register       |
// |            CDB_confirm[N]      - one-hot bus grant pulse               |
// |            Finished[N]         - one-hot completion pulse              |
// |            CDB_valid/tag/value - bus broadcast                         |
// |            RF_we/addr/data     - register-file write port              |
// |            Busy                - arbiter not idle                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int             N        = 4,
  parameter int             W        = 16,
  parameter logic [W-1:0]   NO_VALUE = 16'hFFF0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N-1:0]      Done,
  input  logic [3*N-1:0]    Tag_in,
  input  logic [W*N-1:0]    Value_in,
  input  logic [3*N-1:0]    R_target_in,
  output logic [N-1:0]      CDB_confirm,
  output logic [N-1:0]      Finished,
  output logic              CDB_valid,
  output logic [2:0]        CDB_tag,
  output logic [W-1:0]      CDB_value,
  output logic              RF_we,
  output logic [2:0]        RF_addr,
  output logic [W-1:0]      RF_data,
  output logic              Busy
);

  localparam int            IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  c_one = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BCAST = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_win;
  logic            r_mask;
  logic [2:0]      r_tag;
  logic [2:0]      r_tgt;
  logic [W-1:0]    r_val;

  logic [N-1:0]    w_elig;
  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_ptr_nxt;

  // A source is eligible with a live request and a real station tag. The
  // previous winner is held off for one IDLE cycle so a source that drops
  // Done a cycle late is not granted twice.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_elig[i] = Done[i] && (Tag_in[3*i +: 3] != 3'b000) &&
                  !(r_mask && (r_win == IW'(i)));
    end
  end

  // Walk the sources from the highest offset down so the source nearest
  // the pointer is the last one written, i.e. the winner.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      v_idx = (int'(r_ptr) + k) % N;
      if (w_elig[v_idx]) begin
        w_found = 1'b1;
        w_sel   = IW'(v_idx);
      end
    end
  end

  assign w_ptr_nxt = (r_win == IW'(N - 1)) ? '0 : r_win + IW'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_mask      <= 1'b0;
      r_tag       <= 3'b000;
      r_tgt       <= 3'b000;
      r_val       <= '0;
      CDB_confirm <= '0;
      Finished    <= '0;
      CDB_valid   <= 1'b0;
      CDB_tag     <= 3'b000;
      CDB_value   <= NO_VALUE;
      RF_we       <= 1'b0;
      RF_addr     <= 3'b000;
      RF_data     <= NO_VALUE;
      Busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mask <= 1'b0;
          if (w_found) begin
            // Snapshot the winner so later input changes cannot leak
            // into this transaction.
            r_state     <= GRANT;
            r_win       <= w_sel;
            r_tag       <= Tag_in[3*int'(w_sel) +: 3];
            r_tgt       <= R_target_in[3*int'(w_sel) +: 3];
            r_val       <= Value_in[W*int'(w_sel) +: W];
            CDB_confirm <= c_one << w_sel;
            Busy        <= 1'b1;
          end
        end
        GRANT: begin
          r_state     <= BCAST;
          CDB_confirm <= '0;
          CDB_valid   <= 1'b1;
          CDB_tag     <= r_tag;
          CDB_value   <= r_val;
          RF_we       <= 1'b1;
          RF_addr     <= r_tgt;
          RF_data     <= r_val;
          Finished    <= c_one << r_win;
        end
        BCAST: begin
          r_state   <= IDLE;
          r_ptr     <= w_ptr_nxt;
          r_mask    <= 1'b1;
          Finished  <= '0;
          CDB_valid <= 1'b0;
          CDB_tag   <= 3'b000;
          CDB_value <= NO_VALUE;
          RF_we     <= 1'b0;
          RF_addr   <= 3'b000;
          RF_data   <= NO_VALUE;
          Busy      <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          CDB_confirm <= '0;
          Finished    <= '0;
          CDB_valid   <= 1'b0;
          CDB_tag     <= 3'b000;
          CDB_value   <= NO_VALUE;
          RF_we       <= 1'b0;
          RF_addr     <= 3'b000;
          RF_data     <= NO_VALUE;
          Busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_cdb_arbiter                                              |
// | Purpose  : Directed self-checking bench for cdb_arbiter.               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           Clock;
  logic           Reset;
  logic [N-1:0]   Done;
  logic [3*N-1:0] Tag_in;
  logic [W*N-1:0] Value_in;
  logic [3*N-1:0] R_target_in;
  logic [N-1:0]   CDB_confirm;
  logic [N-1:0]   Finished;
  logic           CDB_valid;
  logic [2:0]     CDB_tag;
  logic [W-1:0]   CDB_value;
  logic           RF_we;
  logic [2:0]     RF_addr;
  logic [W-1:0]   RF_data;
  logic           Busy;

  int n_chk;
  int n_err;

  cdb_arbiter #(.N(N), .W(W), .NO_VALUE(16'hFFF0)) u_dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Done        (Done),
    .Tag_in      (Tag_in),
    .Value_in    (Value_in),
    .R_target_in (R_target_in),
    .CDB_confirm (CDB_confirm),
    .Finished    (Finished),
    .CDB_valid   (CDB_valid),
    .CDB_tag     (CDB_tag),
    .CDB_value   (CDB_value),
    .RF_we       (RF_we),
    .RF_addr     (RF_addr),
    .RF_data     (RF_data),
    .Busy        (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " confirm"},  32'(CDB_confirm), 32'h0);
    chk({tag, " finished"}, 32'(Finished),    32'h0);
    chk({tag, " valid"},    32'(CDB_valid),   32'h0);
    chk({tag, " tag"},      32'(CDB_tag),     32'h0);
    chk({tag, " value"},    32'(CDB_value),   32'hFFF0);
    chk({tag, " rf_we"},    32'(RF_we),       32'h0);
    chk({tag, " rf_addr"},  32'(RF_addr),     32'h0);
    chk({tag, " rf_data"},  32'(RF_data),     32'hFFF0);
    chk({tag, " busy"},     32'(Busy),        32'h0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Done  = '0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [2:0] tg, input logic [W-1:0] v,
                         input logic [2:0] tgt);
    Tag_in[3*i +: 3]      = tg;
    Value_in[W*i +: W]    = v;
    R_target_in[3*i +: 3] = tgt;
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    Reset       = 1'b1;
    Done        = '0;
    Tag_in      = '0;
    Value_in    = '0;
    R_target_in = '0;

    // Reset state
    do_reset();
    idle_outputs("reset");

    // Single request from source 2
    set_src(2, 3'b011, 16'h1234, 3'd5);
    Done = 4'b0100;
    tick();
    chk("single grant confirm", 32'(CDB_confirm), 32'h4);
    chk("single grant busy",    32'(Busy),        32'h1);
    chk("single grant valid",   32'(CDB_valid),   32'h0);
    tick();
    chk("single bcast confirm", 32'(CDB_confirm), 32'h0);
    chk("single bcast valid",   32'(CDB_valid),   32'h1);
    chk("single bcast tag",     32'(CDB_tag),     32'h3);
    chk("single bcast value",   32'(CDB_value),   32'h1234);
    chk("single bcast rf_we",   32'(RF_we),       32'h1);
    chk("single bcast rf_addr", 32'(RF_addr),     32'h5);
    chk("single bcast rf_data", 32'(RF_data),     32'h1234);
    chk("single bcast finished",32'(Finished),    32'h4);
    Done = 4'b0000;
    tick();
    idle_outputs("single after");

    // Round-robin burst: every source drops Done one cycle after Finished
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 3'(i + 1), 16'h0100 + 16'(i), 3'(i + 2));
    Done = 4'b1111;
    tick();
    for (int w = 0; w < N; w++) begin
      chk("rr grant", 32'(CDB_confirm), 32'(1 << w));
      tick();
      chk("rr finished", 32'(Finished),  32'(1 << w));
      chk("rr tag",      32'(CDB_tag),   32'(w + 1));
      chk("rr value",    32'(CDB_value), 32'(16'h0100 + w));
      chk("rr rf_addr",  32'(RF_addr),   32'(w + 2));
      tick();
      chk("rr idle busy", 32'(Busy), 32'h0);
      tick();
      Done[w] = 1'b0;
    end
    // Source 3 was still requesting on that last edge but must be masked
    chk("rr mask confirm", 32'(CDB_confirm), 32'h0);
    chk("rr mask busy",    32'(Busy),        32'h0);
    tick();
    chk("rr quiet busy", 32'(Busy), 32'h0);
    Done = 4'b1111;
    tick();
    chk("rr next burst", 32'(CDB_confirm), 32'h1);

    // Late drop by source 1 with source 3 pending
    do_reset();
    Done = 4'b1010;
    tick();
    chk("late grant1", 32'(CDB_confirm), 32'h2);
    tick();
    chk("late fin1", 32'(Finished), 32'h2);
    tick();
    tick();
    Done[1] = 1'b0;
    chk("late grant3", 32'(CDB_confirm), 32'h8);
    tick();
    chk("late fin3", 32'(Finished), 32'h8);
    Done[3] = 1'b0;
    tick();

    // Zero tag is never served
    do_reset();
    set_src(0, 3'b000, 16'h5555, 3'd1);
    Done = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("zero confirm", 32'(CDB_confirm), 32'h0);
      chk("zero rf_we",   32'(RF_we),       32'h0);
      chk("zero busy",    32'(Busy),        32'h0);
    end
    Done = 4'b0000;

    // Input change during GRANT does not reach the broadcast
    set_src(1, 3'b010, 16'h00AA, 3'd4);
    Done = 4'b0010;
    tick();
    chk("hold grant", 32'(CDB_confirm), 32'h2);
    Value_in[W*1 +: W] = 16'h00BB;
    tick();
    chk("hold value",   32'(CDB_value), 32'h00AA);
    chk("hold rf_data", 32'(RF_data),   32'h00AA);
    chk("hold rf_addr", 32'(RF_addr),   32'h4);
    Done = 4'b0000;
    tick();

    // Reset while in GRANT aborts; pointer restarts at source 0
    set_src(0, 3'b001, 16'h0011, 3'd1);
    set_src(2, 3'b011, 16'h0022, 3'd2);
    Done = 4'b0101;
    tick();
    chk("rst grant2", 32'(CDB_confirm), 32'h4);
    Reset = 1'b1;
    tick();
    idle_outputs("rst midop");
    Reset = 1'b0;
    tick();
    chk("rst restart", 32'(CDB_confirm), 32'h1);
    Done = 4'b0000;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: N, 4, number of functional-unit sources on the common data bus.
REQ-002 Parameter: W, 16, data width of result values.
REQ-003 Parameter: NO_VALUE, 16'hFFF0, value driven on CDB_value and RF_data when no broadcast is active.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  reset Reset, synchronous, active-high.
REQ-006 Done  input  N  per-source result-ready request, level, held until that source's Finished.
REQ-007 Tag_in  input  3*N  per-source producing reservation-station tag, packed, source i at [3i+2:3i]; 3'b000 means no station.
REQ-008 Value_in  input  W*N  per-source result value, packed, source i at [Wi+W-1:Wi].
REQ-009 R_target_in  input  3*N  per-source destination register, packed.
REQ-010 CDB_confirm  output  N  one-hot bus grant, one-cycle pulse.
REQ-011 Finished  output  N  one-hot completion pulse to the winning station and functional unit.
REQ-012 CDB_valid  output  1  broadcast valid.
REQ-013 CDB_tag  output  3  broadcast tag, matched by stations against their Qj/Qk.
REQ-014 CDB_value  output  W  broadcast result.
REQ-015 RF_we, RF_addr[2:0], RF_data[W-1:0]  output  register-file write port.
REQ-016 Busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, GRANT, BCAST; all outputs are registered.
REQ-018 A source i SHALL be eligible only when Done[i]=1, its Tag_in slice is nonzero, and it is not masked per REQ-024.
REQ-019 In IDLE with at least one eligible source, the block SHALL select a winner round-robin: it searches ascending from pointer ptr, modulo N. It then goes to GRANT.
REQ-020 On the IDLE->GRANT edge, the block SHALL latch the winner's index, tag, value and R_target. Later changes on the inputs SHALL NOT affect that transaction.
REQ-021 In GRANT, CDB_confirm[winner]=1 for exactly one cycle and all other bits are 0. GRANT SHALL go unconditionally to BCAST.
REQ-022 In BCAST, for exactly one cycle, the block SHALL drive:
- CDB_valid=1, CDB_tag=latched tag, CDB_value=latched value;
- RF_we=1, RF_addr=latched R_target, RF_data=latched value;
- Finished[winner]=1.
REQ-023 On leaving BCAST, the block SHALL set ptr to (winner+1) mod N and go to IDLE.
REQ-024 During the first IDLE cycle after BCAST, the previous winner SHALL be masked. This prevents a re-grant when Done is still high because the source drops it one cycle late.
REQ-025 While CDB_valid=0, the block SHALL drive CDB_tag=3'b000 and CDB_value=NO_VALUE. While RF_we=0, it SHALL drive RF_addr=3'b000 and RF_data=NO_VALUE.
REQ-026 Worst-case timing: Done to CDB_confirm is 1 cycle; Done to broadcast is 2 cycles; sustained throughput is one broadcast per 3 cycles.
REQ-027 Simultaneous requests SHALL cause no lost request. Every eligible source SHALL be granted within N transactions.
REQ-028 Done deasserting while in GRANT or BCAST SHALL NOT abort the transaction.
REQ-029 A request with Tag_in=3'b000 SHALL be ignored indefinitely, with no grant, no Finished and no register write.

Reset
REQ-030 While Reset=1 at a rising edge, the block SHALL set state=IDLE, ptr=0, mask cleared, and clear all latched fields.
REQ-031 During reset, the block SHALL drive CDB_confirm=0, Finished=0, CDB_valid=0, RF_we=0 and Busy=0. CDB_tag and RF_addr SHALL be 3'b000, and CDB_value and RF_data SHALL be NO_VALUE.
REQ-032 Reset asserted in GRANT or BCAST SHALL abort the transaction. No Finished pulse and no register write SHALL occur on or after that edge.

Verification
REQ-033 Single request: Done[2]=1, tag=3'b011, value=16'h1234, target=5 -> CDB_confirm=4'b0100 at cycle 1. Cycle 2 gives CDB_valid=1, tag 3, value 1234, RF_we=1 with addr 5, and Finished=4'b0100.
REQ-034 Round-robin: Done=4'b1111 held, each source dropping Done one cycle after its Finished -> grant order 0,1,2,3. The next burst starts at 0, with no source granted twice.
REQ-035 Late drop: source 1 keeps Done high one cycle after Finished -> no second grant to source 1. With Done[3] also pending, source 3 is granted next.
REQ-036 Zero tag: Done[0]=1 with tag 3'b000 for 20 cycles -> no CDB_confirm, no RF_we, and Busy stays 0.
REQ-037 Input change: Value_in[1] changes from 16'h00AA to 16'h00BB in the GRANT cycle -> the broadcast carries 16'h00AA.
REQ-038 Reset mid-op: Reset=1 in the GRANT cycle -> the next cycle shows CDB_valid=0, Finished=0, Busy=0 and CDB_value=16'hFFF0. After release, arbitration restarts from source 0.
